// File: rtl/mult_radix4_sequencer.sv
// mult_radix4_sequencer: iterative unsigned radix-4 multiplier.
// Takes one operand pair over a valid/ready handshake. Retires one radix-4
// digit of the multiplier per cycle into a 2*WIDTH-bit accumulator, then
// holds the product until the downstream valid/ready handshake completes.
// Optional build macro: MULT_RADIX4_EARLY_TERM_EN. When it is defined, the
// operation finishes as soon as the remaining multiplier bits are all zero.
module mult_radix4_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int KW = $clog2(WIDTH / 2);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH+1:0]   a3_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [KW-1:0]      k;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product_reg;

    logic [WIDTH+1:0]   pp;
    logic [2*WIDTH-1:0] pp_shifted;
    logic [2*WIDTH-1:0] acc_sum;
    logic               last_digit;
    logic               accept;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = product_reg;

    // Select the partial product for the current multiplier digit.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        pp = '0;
        unique case (b_reg[1:0])
            2'd0: pp = '0;
            2'd1: pp = {2'b00, a_reg};
            2'd2: pp = {1'b0, a_reg, 1'b0};
            2'd3: pp = a3_reg;
        endcase
    end

    // Align the partial product to digit k. Truncation to 2*WIDTH bits is lossless.
    assign pp_shifted = {{(WIDTH - 2){1'b0}}, pp} << {k, 1'b0};
    assign acc_sum    = acc + pp_shifted;

`ifdef MULT_RADIX4_EARLY_TERM_EN
    assign last_digit = (k == K_LAST) || (b_reg[WIDTH-1:2] == '0);
`else
    assign last_digit = (k == K_LAST);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (last_digit) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, retire one digit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are plain registers, not a memory array, so all of them are cleared by reset.
        if (rst) begin
            a_reg       <= '0;
            a3_reg      <= '0;
            b_reg       <= '0;
            k           <= '0;
            acc         <= '0;
            product_reg <= '0;
        end else if (accept) begin
            a_reg  <= op_a;
            a3_reg <= {2'b00, op_a} + {1'b0, op_a, 1'b0};
            b_reg  <= op_b;
            k      <= '0;
            acc    <= '0;
        end else if (state == RUN) begin
            acc   <= acc_sum;
            b_reg <= b_reg >> 2;
            k     <= k + 1'b1;
            if (last_digit) product_reg <= acc_sum;
        end
    end

endmodule

// File: tb/tb_mult_radix4_sequencer.sv
// tb_mult_radix4_sequencer: directed-vector bench for mult_radix4_sequencer (WIDTH = 32).
// Expected latencies follow MULT_RADIX4_EARLY_TERM_EN when it is defined for the bench too.
`timescale 1ns/1ps
module tb_mult_radix4_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      product;
    logic             busy;

    int total = 0;
    int bad   = 0;

    mult_radix4_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Number of RUN edges expected for multiplier b.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MULT_RADIX4_EARLY_TERM_EN
        int msb;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2) / 2;
`else
        return WIDTH / 2;
`endif
    endfunction

    // Present an operand pair and return #1 after the accept edge.
    task automatic start_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    endtask

    // Count edges until out_valid, then check latency, product and in_ready during the run.
    task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
        int  cyc;
        logic ir_seen;
        cyc     = 0;
        ir_seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            ir_seen = ir_seen | in_ready;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_product"}, product, exp);
        check({tag, "_in_ready_low"}, 64'(ir_seen), 64'd0);
    endtask

    // Full operation with out_ready high: handshake on the edge after out_valid rises.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [63:0] exp);
        start_op(tag, a, b);
        wait_done(tag, exp_lat(b), exp);
        @(posedge clk);
        #1;
        check({tag, "_valid_one_cycle"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        #23;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_product",   product,        64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        do_op("aa_x3",  32'hAAAA_AAAA, 32'h0000_0003, 64'h0000_0001_FFFF_FFFE);
        do_op("ff_x2",  32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
        do_op("pow16",  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // Backpressure with a second pair waiting; it must be taken only after the handshake.
        out_ready = 1'b0;
        start_op("bp", 32'h0000_1234, 32'h0000_5678);
        wait_done("bp", exp_lat(32'h0000_5678), 64'h0000_0000_0626_0060);
        in_valid = 1'b1;
        op_a     = 32'h5;
        op_b     = 32'h7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_product_stable", product, 64'h0000_0000_0626_0060);
            check("bp_valid_stable",   64'(out_valid), 64'd1);
            check("bp_in_ready_low",   64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid",    64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepted", 64'(busy), 64'd1);
        wait_done("b2b", exp_lat(32'h7), 64'h23);
        @(posedge clk);
        #1;
        check("b2b_valid_one_cycle", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_no_duplicate", 64'(busy), 64'd0);

        // Reset during the 7th RUN cycle aborts the operation.
        start_op("rstmid", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_product",   product,        64'd0);
        check("rstmid_busy",      64'(busy),      64'd0);
        check("rstmid_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op("after_rst", 32'h2, 32'h3, 64'h6);

        // Early-termination vectors; fixed latency when the feature is off.
        do_op("et_small", 32'h0000_1234, 32'h0000_0003, 64'h0000_369C);
        do_op("et_zero",  32'h0000_1234, 32'h0000_0000, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
